// File: rtl/cmd_subparser_n.sv
// Command-code subparser: code letter + 1..MAX_DIGITS decimal digits + terminator.
// Define CMD_SUBPARSER_M_CODES_EN to accept M codes as well as G codes.
package cmd_subparser_pkg;
  typedef enum logic [2:0] {
    CHAR_G, CHAR_M, CHAR_NUM, CHAR_SPACE, CHAR_NEWLINE, CHAR_OTHER
  } Char_t;
endpackage

module cmd_subparser_n
  import cmd_subparser_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int NUM_WIDTH  = 10,
  parameter int MAX_G_CODE = 99,
  parameter int MAX_M_CODE = 99
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 trigger,
  input  Char_t                char_type,
  input  logic [3:0]           char_digit,
  input  logic                 rd_done,
  input  logic                 rd_rdy,
  input  logic                 is_empty,
  output logic                 done,
  output logic                 rdy,
  output logic                 rd_trigger,
  output logic                 success,
  output logic                 is_m,
  output logic [NUM_WIDTH-1:0] code_num
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  typedef enum logic [3:0] {
    S_IDLE, S_CODE_TRIGGER, S_CODE_WAIT, S_CODE_CHECK, S_WAIT_RD_RDY,
    S_NUM_TRIGGER, S_NUM_WAIT, S_NUM_CHECK, S_VALIDATE, S_SET_SUCCESS, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 success_q, success_d;
  logic                 is_m_q, is_m_d;
  logic [NUM_WIDTH-1:0] code_num_q, code_num_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_WIDTH-1:0] limit;

  // In the default build is_m_q never leaves 0, so the G limit is always selected.
  assign limit = is_m_q ? NUM_WIDTH'(MAX_M_CODE) : NUM_WIDTH'(MAX_G_CODE);

  always_comb begin
    state_d    = state_q;
    success_d  = success_q;
    is_m_d     = is_m_q;
    code_num_d = code_num_q;
    cnt_d      = cnt_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE:
          if (trigger && rd_rdy && !is_empty) state_d = S_CODE_TRIGGER;
        S_CODE_TRIGGER: begin
          success_d  = 1'b0;
          is_m_d     = 1'b0;
          code_num_d = '0;
          cnt_d      = '0;
          if (!rd_rdy) state_d = S_CODE_WAIT;
        end
        S_CODE_WAIT:
          if (rd_done) state_d = S_CODE_CHECK;
        S_CODE_CHECK: begin
          if (char_type == CHAR_G) state_d = S_WAIT_RD_RDY;
`ifdef CMD_SUBPARSER_M_CODES_EN
          else if (char_type == CHAR_M) begin
            is_m_d  = 1'b1;
            state_d = S_WAIT_RD_RDY;
          end
`endif
          else state_d = S_DONE;
        end
        S_WAIT_RD_RDY: begin
          // Running out of characters terminates the number like a space would.
          if (rd_rdy && !is_empty) state_d = S_NUM_TRIGGER;
          else if (is_empty)       state_d = (cnt_q != '0) ? S_VALIDATE : S_DONE;
        end
        S_NUM_TRIGGER:
          if (!rd_rdy) state_d = S_NUM_WAIT;
        S_NUM_WAIT:
          if (rd_done) state_d = S_NUM_CHECK;
        S_NUM_CHECK: begin
          if (char_type == CHAR_NUM) begin
            if (cnt_q < MAX_CNT) begin
              code_num_d = (code_num_q << 3) + (code_num_q << 1) + NUM_WIDTH'(char_digit);
              cnt_d      = cnt_q + CNT_W'(1);
              state_d    = S_WAIT_RD_RDY;
            end else begin
              state_d = S_DONE;
            end
          end else if (char_type == CHAR_SPACE || char_type == CHAR_NEWLINE) begin
            state_d = (cnt_q != '0) ? S_VALIDATE : S_DONE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_VALIDATE:
          state_d = (code_num_q <= limit) ? S_SET_SUCCESS : S_DONE;
        S_SET_SUCCESS: begin
          success_d = 1'b1;
          state_d   = S_DONE;
        end
        S_DONE:
          state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      success_q  <= 1'b0;
      is_m_q     <= 1'b0;
      code_num_q <= '0;
      cnt_q      <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      success_q  <= success_d;
      is_m_q     <= is_m_d;
      code_num_q <= code_num_d;
      cnt_q      <= cnt_d;
    end
  end

  // done: idle and staying idle, in DONE, or on any fail-path jump to DONE.
  assign done = (state_q == S_DONE)
             || (state_q == S_IDLE && state_d == S_IDLE)
             || (state_q != S_IDLE && state_q != S_SET_SUCCESS && state_d == S_DONE);
  assign rdy        = (state_q == S_IDLE);
  assign rd_trigger = (state_q == S_CODE_TRIGGER) || (state_q == S_NUM_TRIGGER);
  assign success    = success_q;
  assign code_num   = code_num_q;
`ifdef CMD_SUBPARSER_M_CODES_EN
  assign is_m = is_m_q;
`else
  assign is_m = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_subparser_n.sv
// Bench for cmd_subparser_n: character-reader model plus expected-result scoreboard.
module tb_cmd_subparser_n;
  import cmd_subparser_pkg::*;

  typedef struct {
    logic       succ;
    logic       m;
    logic [9:0] num;
    int         rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, clk_en, trigger, rd_done, rd_rdy, is_empty;
  Char_t      char_type;
  logic [3:0] char_digit;
  logic       done, rdy, rd_trigger, success, is_m;
  logic [9:0] code_num;

  logic [7:0] stream[$];
  logic [7:0] cur;
  bit         pend, trig_prev, en_prev, done_prev;
  logic       dn_succ;
  int         reads, rises, steps, edges, en_mode;
  int         n_vec, n_err;
  exp_t       exp_q[$];

  cmd_subparser_n dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
    .char_type(char_type), .char_digit(char_digit), .rd_done(rd_done),
    .rd_rdy(rd_rdy), .is_empty(is_empty), .done(done), .rdy(rdy),
    .rd_trigger(rd_trigger), .success(success), .is_m(is_m), .code_num(code_num)
  );

  always #5 clk = ~clk;

  task automatic decode(input logic [7:0] c);
    char_digit = 4'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      char_type  = CHAR_NUM;
      char_digit = 4'(c - 8'h30);
    end else if (c == 8'h47) char_type = CHAR_G;
    else if (c == 8'h4d)     char_type = CHAR_M;
    else if (c == 8'h20)     char_type = CHAR_SPACE;
    else if (c == 8'h0a)     char_type = CHAR_NEWLINE;
    else                     char_type = CHAR_OTHER;
  endtask

  // One clock: reader reacts to what it saw last cycle, inputs change at negedge, outputs sampled 1ns later.
  task automatic step();
    @(negedge clk);
    if (en_prev) begin
      edges++;
      rd_done = 1'b0;
      if (pend) begin
        pend = 1'b0; rd_done = 1'b1; rd_rdy = 1'b1;
        decode(cur);
      end else if (rd_rdy && trig_prev && stream.size() > 0) begin
        rd_rdy = 1'b0; pend = 1'b1;
        cur = stream.pop_front();
        reads++;
      end
    end
    is_empty = (stream.size() == 0);
    steps++;
    clk_en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? (steps % 3 == 0) : 1'b0;
    #1;
    trig_prev = rd_trigger;
    en_prev   = clk_en;
    if (done && !done_prev) rises++;
    done_prev = done;
    if (done && !rdy) dn_succ = success;
  endtask

  task automatic parse(input string s, output int nrd, output int nrise, output bit to);
    int n, r0, d0;
    stream.delete();
    for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
    is_empty = (s.len() == 0);
    r0 = reads; d0 = rises; n = 0; to = 1'b0;
    dn_succ = 1'bx;
    trigger = 1'b1;
    do begin step(); n++; end while (rdy && n < 50);
    if (n >= 50) to = 1'b1;
    trigger = 1'b0;
    while (!rdy && n < 2000) begin step(); n++; end
    if (n >= 2000) to = 1'b1;
    nrd = reads - r0;
    nrise = rises - d0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en_mode = 2;
    step(); step();
    n_vec += 6;
    if (done !== 1'b1)       begin n_err++; $display("FAIL reset done: got %b want 1", done); end
    if (rdy !== 1'b1)        begin n_err++; $display("FAIL reset rdy: got %b want 1", rdy); end
    if (rd_trigger !== 1'b0) begin n_err++; $display("FAIL reset rd_trigger: got %b want 0", rd_trigger); end
    if (success !== 1'b0)    begin n_err++; $display("FAIL reset success: got %b want 0", success); end
    if (is_m !== 1'b0)       begin n_err++; $display("FAIL reset is_m: got %b want 0", is_m); end
    if (code_num !== 10'd0)  begin n_err++; $display("FAIL reset code_num: got %0d want 0", code_num); end
    reset = 1'b0; en_mode = 0;
    step();
  endtask

  task automatic test_ignored_trigger();
    int r0;
    stream.delete();
    r0 = reads;
    step();
    trigger = 1'b1;
    #1;
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL ignored done: got %b want 1", done); end
    repeat (3) step();
    trigger = 1'b0;
    n_vec += 2;
    if (rdy !== 1'b1)    begin n_err++; $display("FAIL ignored rdy: got %b want 1", rdy); end
    if (reads != r0)     begin n_err++; $display("FAIL ignored reads: got %0d want 0", reads - r0); end
  endtask

  task automatic test_streams();
    string vs[12] = '{"G01 ", "G1234 ", "M5\n", "G5", "G", "G100 ",
                      "X", "G ", "G007\n", "G099 ", "G9X", "M100 "};
    exp_t tbl[12] = '{
      '{1'b1, 1'b0, 10'd1,   4}, '{1'b0, 1'b0, 10'd123, 5}, '{1'b0, 1'b0, 10'd0, 1},
      '{1'b1, 1'b0, 10'd5,   2}, '{1'b0, 1'b0, 10'd0,   1}, '{1'b0, 1'b0, 10'd100, 5},
      '{1'b0, 1'b0, 10'd0,   1}, '{1'b0, 1'b0, 10'd0,   2}, '{1'b1, 1'b0, 10'd7, 5},
      '{1'b1, 1'b0, 10'd99,  5}, '{1'b0, 1'b0, 10'd9,   3}, '{1'b0, 1'b0, 10'd0, 1}};
    exp_t e;
    int nrd, nrise;
    bit to;
`ifdef CMD_SUBPARSER_M_CODES_EN
    tbl[2]  = '{1'b1, 1'b1, 10'd5,   3};
    tbl[11] = '{1'b0, 1'b1, 10'd100, 5};
`endif
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(tbl[i]);
      parse(vs[i], nrd, nrise, to);
      e = exp_q.pop_front();
      n_vec += 7;
      if (to)              begin n_err++; $display("FAIL stream[%0d] timeout", i); end
      if (success !== e.succ) begin n_err++; $display("FAIL stream[%0d] success: got %b want %b", i, success, e.succ); end
      if (is_m !== e.m)    begin n_err++; $display("FAIL stream[%0d] is_m: got %b want %b", i, is_m, e.m); end
      if (code_num !== e.num) begin n_err++; $display("FAIL stream[%0d] code_num: got %0d want %0d", i, code_num, e.num); end
      if (nrd != e.rd)     begin n_err++; $display("FAIL stream[%0d] reads: got %0d want %0d", i, nrd, e.rd); end
      if (nrise != 1)      begin n_err++; $display("FAIL stream[%0d] done rises: got %0d want 1", i, nrise); end
      if (dn_succ !== e.succ) begin n_err++; $display("FAIL stream[%0d] success in DONE: got %b want %b", i, dn_succ, e.succ); end
    end
  endtask

  task automatic test_clk_en();
    int nrd, nrise, e0, s0, e1, s1, ea, sa;
    bit to;
    en_mode = 0;
    ea = edges; sa = steps;
    parse("G42 ", nrd, nrise, to);
    e0 = edges - ea; s0 = steps - sa;
    en_mode = 1;
    ea = edges; sa = steps;
    parse("G42 ", nrd, nrise, to);
    e1 = edges - ea; s1 = steps - sa;
    en_mode = 0;
    n_vec += 5;
    if (to)                 begin n_err++; $display("FAIL clk_en timeout"); end
    if (success !== 1'b1)   begin n_err++; $display("FAIL clk_en success: got %b want 1", success); end
    if (code_num !== 10'd42) begin n_err++; $display("FAIL clk_en code_num: got %0d want 42", code_num); end
    if (e1 != e0)           begin n_err++; $display("FAIL clk_en enabled edges: got %0d want %0d", e1, e0); end
    if (s1 < 3*e0 - 3 || s1 > 3*e0 + 3)
      begin n_err++; $display("FAIL clk_en total cycles: got %0d want about %0d (base %0d)", s1, 3*e0, s0); end
  endtask

  task automatic test_reset_mid();
    int r0, n;
    stream.delete();
    stream.push_back(8'h47); stream.push_back(8'h34);
    stream.push_back(8'h35); stream.push_back(8'h20);
    is_empty = 1'b0;
    r0 = reads; n = 0;
    trigger = 1'b1;
    do begin step(); n++; end while (rdy && n < 50);
    trigger = 1'b0;
    // Third read is the second digit; rd_trigger low afterwards means NUM_WAIT.
    while (!((reads - r0) == 3 && !rd_trigger) && n < 200) begin step(); n++; end
    n_vec += 2;
    if (n >= 200)           begin n_err++; $display("FAIL reset_mid timeout reaching NUM_WAIT"); end
    if (code_num !== 10'd4) begin n_err++; $display("FAIL reset_mid pre code_num: got %0d want 4", code_num); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec += 6;
    if (done !== 1'b1)       begin n_err++; $display("FAIL reset_mid done: got %b want 1", done); end
    if (rdy !== 1'b1)        begin n_err++; $display("FAIL reset_mid rdy: got %b want 1", rdy); end
    if (rd_trigger !== 1'b0) begin n_err++; $display("FAIL reset_mid rd_trigger: got %b want 0", rd_trigger); end
    if (success !== 1'b0)    begin n_err++; $display("FAIL reset_mid success: got %b want 0", success); end
    if (is_m !== 1'b0)       begin n_err++; $display("FAIL reset_mid is_m: got %b want 0", is_m); end
    if (code_num !== 10'd0)  begin n_err++; $display("FAIL reset_mid code_num: got %0d want 0", code_num); end
    repeat (3) step();
    n_vec++;
    if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_mid stays idle: got rdy %b want 1", rdy); end
    stream.delete();
    step();
  endtask

  task automatic test_back_to_back();
    int nrd, nrise;
    bit to;
    exp_t e;
    exp_q.push_back('{1'b1, 1'b0, 10'd12, 4});
    exp_q.push_back('{1'b1, 1'b0, 10'd34, 4});
    parse("G12 ", nrd, nrise, to);
    e = exp_q.pop_front();
    n_vec += 3;
    if (to)                 begin n_err++; $display("FAIL b2b[0] timeout"); end
    if (code_num !== e.num) begin n_err++; $display("FAIL b2b[0] code_num: got %0d want %0d", code_num, e.num); end
    if (nrd != e.rd)        begin n_err++; $display("FAIL b2b[0] reads: got %0d want %0d", nrd, e.rd); end
    parse("G34\n", nrd, nrise, to);
    e = exp_q.pop_front();
    repeat (5) step();
    n_vec += 4;
    if (to)                 begin n_err++; $display("FAIL b2b[1] timeout"); end
    if (success !== e.succ) begin n_err++; $display("FAIL b2b[1] success hold: got %b want %b", success, e.succ); end
    if (code_num !== e.num) begin n_err++; $display("FAIL b2b[1] code_num hold: got %0d want %0d", code_num, e.num); end
    if (nrd != e.rd)        begin n_err++; $display("FAIL b2b[1] reads: got %0d want %0d", nrd, e.rd); end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; trigger = 1'b0;
    rd_done = 1'b0; rd_rdy = 1'b1; is_empty = 1'b1;
    char_type = CHAR_OTHER; char_digit = 4'd0;
    pend = 1'b0; trig_prev = 1'b0; en_prev = 1'b1; done_prev = 1'b1;
    reads = 0; rises = 0; steps = 0; edges = 0; en_mode = 0;
    n_vec = 0; n_err = 0;
    test_reset();
    test_ignored_trigger();
    test_streams();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
